apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_master.sv | 155 +++++++++++++++
 tb/tb_apb_master.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master and its companion slave blocks.
package apb_pkg;

    typedef logic [2:0] apb_state_t;

    localparam apb_state_t IDLE   = 3'd0;
    localparam apb_state_t SETUP  = 3'd1;
    localparam apb_state_t ACCESS = 3'd2;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    localparam int MEM_DEPTH_DEF = 32;
    localparam int TIMEOUT_DEF   = 16;

    // The top address bit picks between the two slaves.
    function automatic logic slave1_sel(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1];
    endfunction

endpackage

// File: rtl/apb_master.sv
// Free-running APB master: issues back-to-back SETUP/ACCESS transfers,
// captures read data, and flags address, timeout and direction errors.
//
// state  | meaning
// IDLE   | after reset or a timeout abort; no slave selected
// SETUP  | address and direction registered, select asserted
// ACCESS | PENABLE high, waiting for PREADY (bounded by TIMEOUT)
module apb_master
    import apb_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] pwrite_addr,
    input  logic [ADDR_W-1:0] pread_addr,
    input  logic              write_read,
    output logic              PSELECT1,
    output logic              PSELECT2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] data_out,
    output logic [2:0]        state,
    output logic [2:0]        next_state,
    output logic              PSLVERR,
    output logic              error1,
    output logic              error2,
    output logic              error3
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              error1_q, error1_d;
    logic              error2_q, error2_d;
    logic              error3_q, error3_d;

    logic in_access;
    logic in_transfer;
    logic timeout;
    logic addr_err;
    logic done;

    assign in_access   = (state_q == ACCESS);
    assign in_transfer = (state_q == SETUP) || in_access;
    // The wait counter reaches zero only after TIMEOUT stalled ACCESS cycles.
    assign timeout     = in_access && (wait_cnt_q == '0);
    assign addr_err    = (32'(paddr_q[5:0]) >= MEM_DEPTH);
    assign done        = in_access && PREADY && !timeout;

    // Next-state selection; reset forces IDLE so next_state also reads 0.
    always_comb begin
        state_d = state_q;
        if (PRESET) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = SETUP;
                SETUP:   state_d = ACCESS;
                ACCESS: begin
                    if (timeout)     state_d = IDLE;
                    else if (PREADY) state_d = SETUP;
                    else             state_d = ACCESS;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Transfer datapath: address on SETUP entry, write data on ACCESS entry.
    always_comb begin
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        data_out_d = data_out_q;
        wait_cnt_d = wait_cnt_q;
        if (state_d == SETUP) begin
            pwrite_d = write_read;
            paddr_d  = write_read ? pwrite_addr : pread_addr;
        end
        if (state_q == SETUP) begin
            pwdata_d   = data_in;
            wait_cnt_d = CNT_W'(TIMEOUT);
        end
        if (in_access && !PREADY && (wait_cnt_q != '0)) begin
            wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
        if (done && !pwrite_q && !addr_err) begin
            data_out_d = PRDATA;
        end
    end

    // Error flags are only ever set for a cycle that will be spent in ACCESS.
    always_comb begin
        error1_d = 1'b0;
        error2_d = 1'b0;
        error3_d = 1'b0;
        if (state_d == ACCESS) begin
            error1_d = addr_err;
            error2_d = in_access && !PREADY && (wait_cnt_q == CNT_W'(1));
            error3_d = (write_read != pwrite_q);
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            data_out_q <= '0;
            wait_cnt_q <= '0;
            error1_q   <= 1'b0;
            error2_q   <= 1'b0;
            error3_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            data_out_q <= data_out_d;
            wait_cnt_q <= wait_cnt_d;
            error1_q   <= error1_d;
            error2_q   <= error2_d;
            error3_q   <= error3_d;
        end
    end

    assign PSELECT1   = in_transfer && slave1_sel(paddr_q);
    assign PSELECT2   = in_transfer && !slave1_sel(paddr_q);
    assign PENABLE    = in_access;
    assign PWRITE     = pwrite_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign data_out   = data_out_q;
    assign state      = state_q;
    assign next_state = state_d;
    assign error1     = error1_q;
    assign error2     = error2_q;
    assign error3     = error3_q;
    assign PSLVERR    = (error1_q || error2_q || error3_q) && in_access;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: vector table for slave traffic, hand sequences for
// error/timeout/reset corners, then a randomized run against a schedule model.
module tb_apb_master;
    import apb_pkg::*;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic [7:0] data_in = 8'h00;
    logic [6:0] pwrite_addr = 7'h00;
    logic [6:0] pread_addr = 7'h00;
    logic       write_read = 1'b0;
    logic       PSELECT1, PSELECT2, PENABLE, PWRITE, PSLVERR;
    logic [6:0] PADDR;
    logic [7:0] PWDATA, data_out;
    logic [2:0] state, next_state;
    logic       error1, error2, error3;

    apb_master dut (
        .PCLK(PCLK), .PRESET(PRESET), .PRDATA(PRDATA), .PREADY(PREADY),
        .data_in(data_in), .pwrite_addr(pwrite_addr), .pread_addr(pread_addr),
        .write_read(write_read), .PSELECT1(PSELECT1), .PSELECT2(PSELECT2),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .data_out(data_out), .state(state), .next_state(next_state),
        .PSLVERR(PSLVERR), .error1(error1), .error2(error2), .error3(error3)
    );

    always #5 PCLK = ~PCLK;

    // Two zero-wait slave memories, muxed on PADDR[6].
    logic [7:0] mem1 [64];
    logic [7:0] mem2 [64];
    logic       ready_ctl = 1'b1;
    assign PREADY = ready_ctl;
    assign PRDATA = PADDR[6] ? mem1[PADDR[5:0]] : mem2[PADDR[5:0]];
    always @(posedge PCLK) begin
        if (PENABLE && PWRITE && PREADY) begin
            if (PSELECT1) mem1[PADDR[5:0]] = PWDATA;
            if (PSELECT2) mem2[PADDR[5:0]] = PWDATA;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, state, IDLE);
        chk({tag, "_next"}, next_state, 3'd0);
        chk({tag, "_psel1"}, PSELECT1, 0);
        chk({tag, "_psel2"}, PSELECT2, 0);
        chk({tag, "_penable"}, PENABLE, 0);
        chk({tag, "_pwrite"}, PWRITE, 0);
        chk({tag, "_paddr"}, PADDR, 0);
        chk({tag, "_pwdata"}, PWDATA, 0);
        chk({tag, "_dout"}, data_out, 0);
        chk({tag, "_pslverr"}, PSLVERR, 0);
        chk({tag, "_err"}, {error1, error2, error3}, 0);
    endtask

    typedef struct {
        logic       wr;
        logic [6:0] addr;
        logic [7:0] din;
        logic       exp_sel1;
        logic [7:0] exp_dout;
    } vec_t;

    typedef struct {
        logic       wr;
        logic [6:0] wa;
        logic [6:0] ra;
        logic [7:0] din;
    } in_t;

    localparam int NV = 24;
    localparam int NR = 300;

    vec_t       vec [NV];
    in_t        h [NR + 1];
    logic [7:0] model_mem [128];
    logic [7:0] last_dout;
    logic [7:0] dout_exp;
    logic [7:0] exp_pwdata;
    logic [6:0] addr;
    logic       dir, acc, e1, e3;
    int         ts;

    task automatic apply_vec(input vec_t v);
        write_read  = v.wr;
        pwrite_addr = v.wr ? v.addr : ~v.addr;
        pread_addr  = v.wr ? ~v.addr : v.addr;
        data_in     = v.din;
    endtask

    task automatic rand_inputs(input logic prev_wr, output in_t r);
        r.wr  = ($urandom_range(0, 3) == 0) ? ~prev_wr : prev_wr;
        r.wa  = 7'($urandom_range(0, 127));
        r.ra  = 7'($urandom_range(0, 127));
        r.din = 8'($urandom_range(0, 255));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem1[i] = 8'h00;
            mem2[i] = 8'h00;
        end
        for (int i = 0; i < 6; i++) begin
            vec[i]      = '{wr: 1'b1, addr: 7'(64 + i), din: 8'(i),     exp_sel1: 1'b1, exp_dout: 8'h00};
            vec[i + 6]  = '{wr: 1'b0, addr: 7'(64 + i), din: 8'hEE,     exp_sel1: 1'b1, exp_dout: 8'(i)};
            vec[i + 12] = '{wr: 1'b1, addr: 7'(i),      din: 8'(2 * i), exp_sel1: 1'b0, exp_dout: 8'h00};
            vec[i + 18] = '{wr: 1'b0, addr: 7'(i),      din: 8'hEE,     exp_sel1: 1'b0, exp_dout: 8'(2 * i)};
        end

        // Power-on reset.
        apply_vec(vec[0]);
        repeat (2) @(negedge PCLK);
        chk_reset("por");
        PRESET = 1'b0;

        // Table-driven transfers: slave 1 writes/reads, slave 2 writes/reads.
        last_dout = 8'h00;
        for (int i = 0; i < NV; i++) begin
            @(negedge PCLK);
            chk("setup_state", state, SETUP);
            chk("setup_penable", PENABLE, 0);
            chk("setup_next", next_state, ACCESS);
            if (i > 0 && !vec[i - 1].wr) begin
                chk("read_data", data_out, vec[i - 1].exp_dout);
                last_dout = vec[i - 1].exp_dout;
            end
            @(negedge PCLK);
            chk("access_state", state, ACCESS);
            chk("access_penable", PENABLE, 1);
            chk("access_psel1", PSELECT1, vec[i].exp_sel1);
            chk("access_psel2", PSELECT2, !vec[i].exp_sel1);
            chk("access_paddr", PADDR, vec[i].addr);
            chk("access_pwrite", PWRITE, vec[i].wr);
            chk("access_pslverr", PSLVERR, 0);
            chk("dout_hold", data_out, last_dout);
            if (vec[i].wr) chk("access_pwdata", PWDATA, vec[i].din);
            if (i + 1 < NV) apply_vec(vec[i + 1]);
        end
        @(negedge PCLK);
        chk("last_read_data", data_out, 8'd10);

        // Direction change during SETUP: flagged, transfer keeps read direction.
        write_read  = 1'b1;
        pwrite_addr = 7'h10;
        data_in     = 8'h77;
        @(negedge PCLK);
        chk("dir_err_state", state, ACCESS);
        chk("dir_err_error3", error3, 1);
        chk("dir_err_error1", error1, 0);
        chk("dir_err_pslverr", PSLVERR, 1);
        chk("dir_err_pwrite", PWRITE, 0);
        write_read = 1'b0;
        pread_addr = 7'h25;
        mem2[37]   = 8'hA5;
        @(negedge PCLK);
        chk("addr_setup_state", state, SETUP);
        chk("addr_setup_error3", error3, 0);
        chk("addr_setup_pslverr", PSLVERR, 0);
        chk("addr_setup_paddr", PADDR, 7'h25);
        chk("addr_setup_dout", data_out, 8'd10);

        // Out-of-range address: error1, no data capture.
        @(negedge PCLK);
        chk("addr_err_state", state, ACCESS);
        chk("addr_err_error1", error1, 1);
        chk("addr_err_pslverr", PSLVERR, 1);
        chk("addr_err_psel2", PSELECT2, 1);
        pread_addr = 7'h41;
        @(negedge PCLK);
        chk("addr_err_dout", data_out, 8'd10);
        chk("addr_err_clear", error1, 0);

        // Timeout: PREADY low for TIMEOUT ACCESS cycles.
        ready_ctl = 1'b0;
        for (int k = 1; k <= TIMEOUT_DEF; k++) begin
            @(negedge PCLK);
            chk("wait_state", state, ACCESS);
            chk("wait_error2", error2, 0);
            chk("wait_pslverr", PSLVERR, 0);
        end
        @(negedge PCLK);
        chk("timeout_state", state, ACCESS);
        chk("timeout_error2", error2, 1);
        chk("timeout_pslverr", PSLVERR, 1);
        chk("timeout_next", next_state, IDLE);
        @(negedge PCLK);
        chk("abort_state", state, IDLE);
        chk("abort_error2", error2, 0);
        chk("abort_psel1", PSELECT1, 0);
        chk("abort_psel2", PSELECT2, 0);
        chk("abort_penable", PENABLE, 0);
        chk("abort_dout", data_out, 8'd10);
        ready_ctl = 1'b1;
        @(negedge PCLK);
        chk("resume_state", state, SETUP);

        // Reset in the middle of ACCESS.
        @(negedge PCLK);
        chk("pre_reset_state", state, ACCESS);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk_reset("mid");
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("release_state", state, SETUP);

        // Randomized run against a transfer-schedule model.
        PRESET = 1'b1;
        @(negedge PCLK);
        for (int a = 0; a < 128; a++) model_mem[a] = a[6] ? mem1[a[5:0]] : mem2[a[5:0]];
        rand_inputs(1'b0, h[0]);
        write_read = h[0].wr; pwrite_addr = h[0].wa; pread_addr = h[0].ra; data_in = h[0].din;
        PRESET   = 1'b0;
        dout_exp = 8'h00;
        for (int c = 0; c < NR; c++) begin
            @(negedge PCLK);
            // Cycle c: even = SETUP, odd = ACCESS; h[k] holds inputs seen during cycle k-1.
            acc = (c % 2 == 1);
            ts  = acc ? c - 1 : c;
            dir = h[ts].wr;
            addr = dir ? h[ts].wa : h[ts].ra;
            exp_pwdata = acc ? h[c].din : ((c >= 2) ? h[c - 1].din : 8'h00);
            e1 = acc && (int'(addr[5:0]) >= MEM_DEPTH_DEF);
            e3 = acc && (h[c].wr != dir);
            chk("rnd_state", state, acc ? ACCESS : SETUP);
            chk("rnd_next", next_state, acc ? SETUP : ACCESS);
            chk("rnd_penable", PENABLE, acc);
            chk("rnd_psel1", PSELECT1, addr[6]);
            chk("rnd_psel2", PSELECT2, !addr[6]);
            chk("rnd_paddr", PADDR, addr);
            chk("rnd_pwrite", PWRITE, dir);
            chk("rnd_pwdata", PWDATA, exp_pwdata);
            chk("rnd_dout", data_out, dout_exp);
            chk("rnd_error1", error1, e1);
            chk("rnd_error2", error2, 0);
            chk("rnd_error3", error3, e3);
            chk("rnd_pslverr", PSLVERR, e1 || e3);
            if (acc) begin
                if (dir) model_mem[addr] = h[c].din;
                else if (!e1) dout_exp = model_mem[addr];
            end
            rand_inputs(h[c].wr, h[c + 1]);
            write_read  = h[c + 1].wr;
            pwrite_addr = h[c + 1].wa;
            pread_addr  = h[c + 1].ra;
            data_in     = h[c + 1].din;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
